// File: rtl/axi4_lite_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi4_lite_mem_ctrl
// Purpose  : Memory-side stage behind an AXI4-Lite slave wrapper. It
//            arbitrates between pending reads and writes, alternating
//            under contention. It models a word-addressed backing RAM with
//            fixed read/write latency. It also returns read data plus
//            grant and completion pulses.
// Ports    : clk_i               - clock, rising edge
//            arst_ni             - asynchronous active-low reset
//            read_request_i      - read pending from wrapper
//            write_en_i          - write pending from wrapper
//            addr_i              - byte address (read addr while start_read_o)
//            data_i              - write data
//            data_o              - read data, held until next read completes
//            start_read_o        - read granted (ADDR through RESP)
//            start_write_o       - write granted (ADDR through RESP)
//            successful_read_o   - one-cycle read completion pulse
//            successful_write_o  - one-cycle write completion pulse
//            successful_access_o - with a pulse: 1 = in range, 0 = out of range
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_mem_ctrl #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int READ_LATENCY   = 2,
    parameter int WRITE_LATENCY  = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      read_request_i,
    input  logic                      write_en_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    output logic                      start_read_o,
    output logic                      start_write_o,
    output logic                      successful_read_o,
    output logic                      successful_write_o,
    output logic                      successful_access_o
);

    localparam int c_offs    = $clog2(AXI_DATA_WIDTH / 8);
    localparam int c_idx_w   = $clog2(MEM_DEPTH);
    localparam int c_max_lat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int c_cnt_w   = $clog2(c_max_lat) + 1;

    localparam logic [AXI_ADDR_WIDTH-1:0] c_depth = AXI_ADDR_WIDTH'(MEM_DEPTH);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_r_addr = 3'd1;
    localparam logic [2:0] c_st_r_wait = 3'd2;
    localparam logic [2:0] c_st_r_resp = 3'd3;
    localparam logic [2:0] c_st_w_addr = 3'd4;
    localparam logic [2:0] c_st_w_wait = 3'd5;
    localparam logic [2:0] c_st_w_resp = 3'd6;

    logic [2:0]                r_state;
    logic [2:0]                w_state_next;
    logic                      r_prio_read;
    logic                      w_prio_next;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [AXI_DATA_WIDTH-1:0] r_data_o;
    logic                      r_start_read;
    logic                      r_start_write;
    logic                      r_succ_read;
    logic                      r_succ_write;
    logic                      r_succ_access;

    logic                      w_start_read;
    logic                      w_start_write;
    logic                      w_succ_read;
    logic                      w_succ_write;
    logic                      w_succ_access;

    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Range check uses the full word address so that aliases above the
    // RAM never hit the truncated index.
    logic [AXI_ADDR_WIDTH-1:0] w_word_addr;
    logic [c_idx_w-1:0]        w_idx;
    logic                      w_in_range;
    logic                      w_cnt_zero;

    assign w_word_addr = r_addr >> c_offs;
    assign w_idx       = w_word_addr[c_idx_w-1:0];
    assign w_in_range  = (w_word_addr < c_depth);
    assign w_cnt_zero  = (r_cnt == '0);

    // ------------------------------------------------------------------
    // State register, datapath registers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state       <= c_st_idle;
            r_prio_read   <= 1'b1;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_data_o      <= '0;
            r_start_read  <= 1'b0;
            r_start_write <= 1'b0;
            r_succ_read   <= 1'b0;
            r_succ_write  <= 1'b0;
            r_succ_access <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_prio_read   <= w_prio_next;
            r_start_read  <= w_start_read;
            r_start_write <= w_start_write;
            r_succ_read   <= w_succ_read;
            r_succ_write  <= w_succ_write;
            r_succ_access <= w_succ_access;
            case (r_state)
                c_st_r_addr: begin
                    r_addr <= addr_i;
                    r_cnt  <= c_cnt_w'(READ_LATENCY - 1);
                end
                c_st_w_addr: begin
                    r_addr  <= addr_i;
                    r_wdata <= data_i;
                    r_cnt   <= c_cnt_w'(WRITE_LATENCY - 1);
                end
                c_st_r_wait: begin
                    if (w_cnt_zero) begin
                        r_data_o <= w_in_range ? r_mem[w_idx] : '0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                c_st_w_wait: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Backing RAM has no reset. A reset asserted mid-write forces the state
    // out of W_WAIT asynchronously, so no later edge can commit the write.
    always_ff @(posedge clk_i) begin
        if ((r_state == c_st_w_wait) && w_cnt_zero && w_in_range) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio_read;
        case (r_state)
            c_st_idle: begin
                if (read_request_i && (!write_en_i || r_prio_read)) begin
                    w_state_next = c_st_r_addr;
                    w_prio_next  = 1'b0;
                end else if (write_en_i) begin
                    w_state_next = c_st_w_addr;
                    w_prio_next  = 1'b1;
                end
            end
            c_st_r_addr: w_state_next = c_st_r_wait;
            c_st_r_wait: if (w_cnt_zero) w_state_next = c_st_r_resp;
            c_st_r_resp: w_state_next = c_st_idle;
            c_st_w_addr: w_state_next = c_st_w_wait;
            c_st_w_wait: if (w_cnt_zero) w_state_next = c_st_w_resp;
            c_st_w_resp: w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state. These values are registered, so
    // the outputs line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        w_start_read  = (w_state_next == c_st_r_addr) ||
                        (w_state_next == c_st_r_wait) ||
                        (w_state_next == c_st_r_resp);
        w_start_write = (w_state_next == c_st_w_addr) ||
                        (w_state_next == c_st_w_wait) ||
                        (w_state_next == c_st_w_resp);
        w_succ_read   = (w_state_next == c_st_r_resp);
        w_succ_write  = (w_state_next == c_st_w_resp);
        w_succ_access = (w_succ_read || w_succ_write) && w_in_range;
    end

    assign data_o              = r_data_o;
    assign start_read_o        = r_start_read;
    assign start_write_o       = r_start_write;
    assign successful_read_o   = r_succ_read;
    assign successful_write_o  = r_succ_write;
    assign successful_access_o = r_succ_access;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_mem_ctrl
// Purpose  : Self-checking bench for axi4_lite_mem_ctrl. A transaction-level
//            model predicts every output on every cycle. Directed
//            sequences also pin key results to literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_mem_ctrl;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int DEPTH = 1024;
    localparam int RL = 2;
    localparam int WL = 2;

    logic          clk = 1'b0;
    logic          arst_ni = 1'b1;
    logic          read_request = 1'b0;
    logic          write_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] data_o;
    logic          start_read;
    logic          start_write;
    logic          successful_read;
    logic          successful_write;
    logic          successful_access;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi4_lite_mem_ctrl #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .MEM_DEPTH      (DEPTH),
        .READ_LATENCY   (RL),
        .WRITE_LATENCY  (WL)
    ) dut (
        .clk_i               (clk),
        .arst_ni             (arst_ni),
        .read_request_i      (read_request),
        .write_en_i          (write_en),
        .addr_i              (addr),
        .data_i              (data),
        .data_o              (data_o),
        .start_read_o        (start_read),
        .start_write_o       (start_write),
        .successful_read_o   (successful_read),
        .successful_write_o  (successful_write),
        .successful_access_o (successful_access)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: an access occupies cycles 1..LAT+2 after the
    // grant edge, with its completion pulse on the last of those cycles.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [int];
    bit            m_busy = 1'b0;
    bit            m_wr = 1'b0;
    bit            m_prio = 1'b1;
    bit            m_inr = 1'b0;
    int            m_n = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] e_data = '0;
    bit e_sr = 1'b0, e_sw = 1'b0, e_srd = 1'b0, e_swr = 1'b0, e_acc = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!arst_ni) begin
                m_busy = 1'b0;
                m_prio = 1'b1;
                m_n    = 0;
                e_data = '0;
                e_sr = 1'b0; e_sw = 1'b0; e_srd = 1'b0; e_swr = 1'b0; e_acc = 1'b0;
            end
            chk("m_data_o",        64'(data_o),            64'(e_data));
            chk("m_start_read",    64'(start_read),        64'(e_sr));
            chk("m_start_write",   64'(start_write),       64'(e_sw));
            chk("m_succ_read",     64'(successful_read),   64'(e_srd));
            chk("m_succ_write",    64'(successful_write),  64'(e_swr));
            chk("m_succ_access",   64'(successful_access), 64'(e_acc));
            chk("m_grant_exclusive", 64'(start_read && start_write), 64'(0));
            if (arst_ni) begin
                if (!m_busy) begin
                    if (read_request && (!write_en || m_prio)) begin
                        m_busy = 1'b1; m_wr = 1'b0; m_n = 1; m_prio = 1'b0;
                    end else if (write_en) begin
                        m_busy = 1'b1; m_wr = 1'b1; m_n = 1; m_prio = 1'b1;
                    end
                end else begin
                    int lat;
                    lat = m_wr ? WL : RL;
                    if (m_n == 1) begin
                        m_addr  = addr;
                        m_wdata = data;
                    end
                    if (m_n == lat + 2) begin
                        m_busy = 1'b0;
                    end else begin
                        m_n++;
                        if (m_n == lat + 2) begin
                            int idx;
                            m_inr = (m_addr < 64'(DEPTH) * 64'(DW / 8));
                            idx   = int'((m_addr / 64'(DW / 8)) % 64'(DEPTH));
                            if (!m_wr) e_data = m_inr ? m_mem[idx] : '0;
                            else if (m_inr) m_mem[idx] = m_wdata;
                        end
                    end
                end
                e_sr  = m_busy && !m_wr;
                e_sw  = m_busy && m_wr;
                e_srd = m_busy && !m_wr && (m_n == RL + 2);
                e_swr = m_busy && m_wr && (m_n == WL + 2);
                e_acc = (e_srd || e_swr) && m_inr;
            end
        end
    end

    // One access starting from IDLE; returns the completion data, status
    // and the number of edges from request sampling to the pulse.
    task automatic do_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output logic [DW-1:0] rd, output bit acc, output int lat);
        @(posedge clk); #1;
        addr = a;
        data = d;
        if (wr) write_en = 1'b1;
        else    read_request = 1'b1;
        lat = -1;
        rd  = '0;
        acc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                read_request = 1'b0;
                write_en     = 1'b0;
            end
            if (wr ? successful_write : successful_read) begin
                lat = k;
                rd  = data_o;
                acc = successful_access;
                break;
            end
        end
        if (lat < 0) chk("access_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        logic [DW-1:0] rd;
        bit            acc;
        int            lat;
        bit            grants[$];
        bit            prev_r, prev_w;

        // Reset held three cycles with both requests high.
        #1 arst_ni = 1'b0;
        read_request = 1'b1;
        write_en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_o",      64'(data_o),            64'(0));
        chk("rst_start_read",  64'(start_read),        64'(0));
        chk("rst_start_write", 64'(start_write),       64'(0));
        chk("rst_succ_any",    64'({successful_read, successful_write, successful_access}), 64'(0));
        read_request = 1'b0;
        write_en     = 1'b0;
        @(posedge clk); #1 arst_ni = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_rst", 64'({start_read, start_write}), 64'(0));

        // Write then read back.
        do_access(1'b1, 64'h10, 32'hDEADBEEF, rd, acc, lat);
        chk("wr10_latency", 64'(lat), 64'(4));
        chk("wr10_access",  64'(acc), 64'(1));
        chk("wr10_data_o_unchanged", 64'(data_o), 64'(0));
        do_access(1'b0, 64'h10, 32'h0, rd, acc, lat);
        chk("rd10_latency", 64'(lat), 64'(4));
        chk("rd10_data",    64'(rd),  64'hDEADBEEF);
        chk("rd10_access",  64'(acc), 64'(1));

        // Byte offset inside the same word.
        do_access(1'b1, 64'h20, 32'hA5A5A5A5, rd, acc, lat);
        do_access(1'b0, 64'h23, 32'h0, rd, acc, lat);
        chk("rd23_data", 64'(rd), 64'hA5A5A5A5);

        // Out of range: word 1024 must not alias word 0.
        do_access(1'b1, 64'h0, 32'h12345678, rd, acc, lat);
        do_access(1'b1, 64'h1000, 32'h11111111, rd, acc, lat);
        chk("wr1000_access", 64'(acc), 64'(0));
        do_access(1'b0, 64'h0, 32'h0, rd, acc, lat);
        chk("rd0_data",   64'(rd),  64'h12345678);
        chk("rd0_access", 64'(acc), 64'(1));
        do_access(1'b0, 64'h1000, 32'h0, rd, acc, lat);
        chk("rd1000_data",   64'(rd),  64'(0));
        chk("rd1000_access", 64'(acc), 64'(0));
        do_access(1'b0, 64'hFFC, 32'h0, rd, acc, lat);
        chk("rdFFC_access",  64'(acc), 64'(1));
        do_access(1'b0, 64'h1_0000_0000, 32'h0, rd, acc, lat);
        chk("rd_high_access", 64'(acc), 64'(0));

        // Reset during R_WAIT aborts the read.
        @(posedge clk); #1;
        addr = 64'h10;
        read_request = 1'b1;
        @(posedge clk); #1;
        read_request = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_wait", 64'(start_read), 64'(1));
        #1 arst_ni = 1'b0;
        #1;
        chk("midrst_start_read", 64'(start_read), 64'(0));
        chk("midrst_data_o",     64'(data_o),     64'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_pulse", 64'(successful_read), 64'(0));
        end
        arst_ni = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 64'h10, 32'h0, rd, acc, lat);
        chk("postrst_rd10_data", 64'(rd), 64'hDEADBEEF);

        // Contention from reset: grants must alternate starting with read.
        arst_ni      = 1'b0;
        addr         = 64'h40;
        data         = 32'hCAFEF00D;
        read_request = 1'b1;
        write_en     = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst_ni = 1'b1;
        prev_r = 1'b0;
        prev_w = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (start_read && !prev_r)  grants.push_back(1'b0);
            if (start_write && !prev_w) grants.push_back(1'b1);
            prev_r = start_read;
            prev_w = start_write;
        end
        read_request = 1'b0;
        write_en     = 1'b0;
        chk("cont_grant_count", 64'(grants.size() >= 4), 64'(1));
        if (grants.size() >= 4) begin
            chk("cont_grant0_read",  64'(grants[0]), 64'(0));
            chk("cont_grant1_write", 64'(grants[1]), 64'(1));
            chk("cont_grant2_read",  64'(grants[2]), 64'(0));
            chk("cont_grant3_write", 64'(grants[3]), 64'(1));
        end
        repeat (8) @(posedge clk);
        #1;
        do_access(1'b0, 64'h40, 32'h0, rd, acc, lat);
        chk("rd40_data", 64'(rd), 64'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
